// File: rtl/cpu_boot_sequencer.sv
// Boot sequencer: arbitrates one single-port RAM between a host loader and the CPU.
// The host loads or inspects memory while the CPU is held in reset, then releases it to run.
module cpu_boot_sequencer #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [1:0]        host_cmd,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_rsp_valid,
    output logic [DATA_W-1:0] host_rsp_data,
    output logic              running,
    output logic [31:0]       run_cycles,
    output logic              cpu_reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_data_out,
    output logic [DATA_W-1:0] cpu_data_in,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] CMD_WRITE = 2'b00;
    localparam logic [1:0] CMD_PTR   = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_RUN   = 2'b11;

    typedef enum logic [2:0] {
        S_LOAD,
        S_WR,
        S_RD,
        S_RSP,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [DATA_W-1:0]   r_data;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_cpu_reset;
    logic                r_running;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [31:0]         r_run_cycles;

    logic                w_accept;

    assign host_ready     = (r_state == S_LOAD) || (r_state == S_RUN);
    assign w_accept       = host_valid && host_ready;
    assign host_rsp_valid = r_rsp_valid;
    assign host_rsp_data  = r_rsp_data;
    assign running        = r_running;
    assign run_cycles     = r_run_cycles;
    assign cpu_reset      = r_cpu_reset;
    assign cpu_data_in    = mem_rdata;

    // Memory port mux; the write strobe is masked by reset so an interrupted WR never lands.
    always_comb begin
        mem_address = r_ptr;
        mem_wdata   = r_data;
        mem_we      = 1'b0;
        if (r_state == S_RUN) begin
            mem_address = cpu_address;
            mem_wdata   = cpu_data_out;
            mem_we      = cpu_we;
        end else if (r_state == S_WR) begin
            mem_we = 1'b1;
        end
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_LOAD;
            r_ptr        <= '0;
            r_data       <= '0;
            r_hold_cnt   <= '0;
            r_cpu_reset  <= 1'b1;
            r_running    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_run_cycles <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        case (host_cmd)
                            CMD_WRITE: begin
                                r_data  <= host_data;
                                r_state <= S_WR;
                            end
                            CMD_PTR:  r_ptr   <= host_data[ADDR_W-1:0];
                            CMD_READ: r_state <= S_RD;
                            CMD_RUN: begin
                                r_hold_cnt   <= HOLD_INIT;
                                r_run_cycles <= '0;
                                r_state      <= S_RELEASE;
                            end
                            default: r_state <= S_LOAD;
                        endcase
                    end
                end
                S_WR: begin
                    r_ptr   <= r_ptr + ADDR_W'(1);
                    r_state <= S_LOAD;
                end
                S_RD: begin
                    r_rsp_data  <= mem_rdata;
                    r_rsp_valid <= 1'b1;
                    r_ptr       <= r_ptr + ADDR_W'(1);
                    r_state     <= S_RSP;
                end
                S_RSP: r_state <= S_LOAD;
                S_RELEASE: begin
                    if (r_hold_cnt == '0) begin
                        r_cpu_reset <= 1'b0;
                        r_running   <= 1'b1;
                        r_state     <= S_RUN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    if (r_run_cycles != '1) begin
                        r_run_cycles <= r_run_cycles + 32'd1;
                    end
                    // Only halt is honoured while running; other host commands are dropped.
                    if (w_accept && (host_cmd == CMD_RUN)) begin
                        r_cpu_reset <= 1'b1;
                        r_running   <= 1'b0;
                        r_state     <= S_LOAD;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// Testbench for cpu_boot_sequencer: RAM model, tiny accumulator CPU model, read-response scoreboard.
module tb_cpu_boot_sequencer;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned HOLD_CYCLES = 2;

    logic              clock;
    logic              reset;
    logic              host_valid;
    logic              host_ready;
    logic [1:0]        host_cmd;
    logic [DATA_W-1:0] host_data;
    logic              host_rsp_valid;
    logic [DATA_W-1:0] host_rsp_data;
    logic              running;
    logic [31:0]       run_cycles;
    logic              cpu_reset;
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_data_out;
    logic [DATA_W-1:0] cpu_data_in;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    cpu_boot_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clock(clock), .reset(reset),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_cmd(host_cmd), .host_data(host_data),
        .host_rsp_valid(host_rsp_valid), .host_rsp_data(host_rsp_data),
        .running(running), .run_cycles(run_cycles), .cpu_reset(cpu_reset),
        .cpu_address(cpu_address), .cpu_we(cpu_we),
        .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in),
        .mem_address(mem_address), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int we_count = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ram    [0:65535];
    logic [31:0] shadow [0:65535];
    logic [15:0] tb_ptr;

    always @(posedge clock) cyc++;

    // Async-read, sync-write RAM
    always @(posedge clock) if (mem_we) ram[mem_address] <= mem_wdata;
    assign mem_rdata = ram[mem_address];

    // Minimal accumulator CPU: 4=load imm, 7=store acc, 8=branch; fetch/execute in two cycles
    logic [15:0] pc;
    logic [31:0] ir, acc;
    logic        ph;
    always @(posedge clock) begin
        if (cpu_reset) begin
            pc <= '0; ph <= 1'b0; ir <= '0; acc <= '0;
        end else if (!ph) begin
            ir <= cpu_data_in; pc <= pc + 16'd1; ph <= 1'b1;
        end else begin
            ph <= 1'b0;
            case (ir[31:28])
                4'h4: acc <= {4'h0, ir[27:0]};
                4'h8: pc  <= ir[15:0];
                default: ;
            endcase
        end
    end
    assign cpu_address  = ph ? ir[15:0] : pc;
    assign cpu_we       = ph && (ir[31:28] == 4'h7);
    assign cpu_data_out = acc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Read-response monitor and write-strobe counter
    always @(negedge clock) begin
        if (mem_we) we_count++;
        if (host_rsp_valid) begin
            if (exp_q.size() == 0) check_eq("unexpected_rsp", 32'(host_rsp_valid), 32'd0);
            else check_eq("rsp_data", host_rsp_data, exp_q.pop_front());
        end
    end

    task automatic send(input logic [1:0] cmd, input logic [31:0] data, output int acc_cyc);
        bit ok = 1'b0;
        host_valid = 1'b1; host_cmd = cmd; host_data = data;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (host_ready) ok = 1'b1;
        end
        if (!ok) check_eq("accept_timeout", 32'(host_ready), 32'd1);
        @(posedge clock); #1;
        acc_cyc = cyc;
        host_valid = 1'b0;
    endtask

    task automatic setp(input logic [15:0] a);
        int c;
        send(2'b01, {16'h0, a}, c);
        tb_ptr = a;
    endtask

    task automatic wr(input logic [31:0] d);
        int c;
        send(2'b00, d, c);
        shadow[tb_ptr] = d;
        tb_ptr = tb_ptr + 16'd1;
    endtask

    task automatic rd();
        int c;
        exp_q.push_back(shadow[tb_ptr]);
        send(2'b10, 32'h0, c);
        tb_ptr = tb_ptr + 16'd1;
        @(negedge clock); check_eq("rsp_early", 32'(host_rsp_valid), 32'd0);
        @(negedge clock); check_eq("rsp_pulse", 32'(host_rsp_valid), 32'd1);
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int a_cyc, h_cyc, c, w0;
        logic [31:0] exp_rc;
        for (int i = 0; i < 65536; i++) begin ram[i] = '0; shadow[i] = '0; end
        reset = 1'b1; host_valid = 1'b0; host_cmd = 2'b00; host_data = '0; tb_ptr = '0;
        idle(3);
        @(negedge clock);
        check_eq("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check_eq("rst_ready",     32'(host_ready), 32'd1);
        check_eq("rst_running",   32'(running), 32'd0);
        check_eq("rst_rsp_valid", 32'(host_rsp_valid), 32'd0);
        check_eq("rst_rsp_data",  host_rsp_data, 32'd0);
        check_eq("rst_run_cyc",   run_cycles, 32'd0);
        check_eq("rst_ptr",       32'(mem_address), 32'd0);
        check_eq("rst_mem_we",    32'(mem_we), 32'd0);
        @(posedge clock); #1; reset = 1'b0;

        // Host writes
        setp(16'h0000);
        w0 = we_count;
        wr(32'h40000005);
        wr(32'h70000010);
        idle(2);
        @(negedge clock);
        check_eq("ram0", ram[0], 32'h40000005);
        check_eq("ram1", ram[1], 32'h70000010);
        check_eq("we_pulses", 32'(we_count - w0), 32'd2);
        check_eq("ptr_after_wr", 32'(mem_address), 32'd2);
        check_eq("load_cpu_reset", 32'(cpu_reset), 32'd1);
        @(posedge clock); #1;

        // Host read
        setp(16'h0001);
        rd();
        @(negedge clock); check_eq("ptr_after_rd", 32'(mem_address), 32'd2);
        @(posedge clock); #1;

        // Program load and release
        setp(16'h0000);
        wr(32'h40000005); wr(32'h70000010); wr(32'h80000002);
        send(2'b11, 32'h0, a_cyc);
        @(negedge clock); check_eq("rel1_cpu_reset", 32'(cpu_reset), 32'd1);
        check_eq("rel1_ready", 32'(host_ready), 32'd0);
        @(negedge clock); check_eq("rel2_cpu_reset", 32'(cpu_reset), 32'd1);
        @(negedge clock); check_eq("run_cpu_reset", 32'(cpu_reset), 32'd0);
        check_eq("run_running", 32'(running), 32'd1);
        for (int i = 0; i < 6 && ram[16'h0010] != 32'd5; i++) @(negedge clock);
        check_eq("cpu_store", ram[16'h0010], 32'd5);
        shadow[16'h0010] = 32'd5;
        check_eq("cpu_data_in", cpu_data_in, ram[mem_address]);
        @(posedge clock); #1;

        // Host commands other than halt are dropped while running
        send(2'b10, 32'h0, c);
        send(2'b01, 32'h0040, c);
        send(2'b00, 32'hDEADBEEF, c);
        idle(3);
        @(negedge clock); check_eq("still_running", 32'(running), 32'd1);
        @(posedge clock); #1;

        // Halt
        send(2'b11, 32'h0, h_cyc);
        exp_rc = 32'(h_cyc - (a_cyc + 2));
        @(negedge clock);
        check_eq("halt_cpu_reset", 32'(cpu_reset), 32'd1);
        check_eq("halt_running", 32'(running), 32'd0);
        check_eq("halt_run_cyc", run_cycles, exp_rc);
        idle(3);
        @(negedge clock);
        check_eq("frozen_run_cyc", run_cycles, exp_rc);
        check_eq("halt_ptr", 32'(mem_address), 32'd3);
        check_eq("dropped_wr", ram[3], shadow[3]);
        @(posedge clock); #1;
        setp(16'h0010);
        rd();

        // Pointer wrap
        setp(16'hFFFF);
        wr(32'h0000000A); wr(32'h0000000B);
        idle(2);
        @(negedge clock);
        check_eq("wrap_hi", ram[16'hFFFF], 32'h0000000A);
        check_eq("wrap_lo", ram[16'h0000], 32'h0000000B);
        check_eq("wrap_ptr", 32'(mem_address), 32'd1);
        @(posedge clock); #1;
        setp(16'hFFFF);
        rd(); rd();

        // Reset during WR
        setp(16'h0020);
        send(2'b00, 32'h12345678, c);
        reset = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        tb_ptr = '0;
        @(negedge clock);
        check_eq("rstwr_ram", ram[16'h0020], 32'h0);
        check_eq("rstwr_ptr", 32'(mem_address), 32'd0);
        check_eq("rstwr_cpu_reset", 32'(cpu_reset), 32'd1);
        check_eq("rstwr_ready", 32'(host_ready), 32'd1);
        @(posedge clock); #1;

        // Reset during RD
        setp(16'h0001);
        send(2'b10, 32'h0, c);
        reset = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); check_eq("rstrd_no_rsp", 32'(host_rsp_valid), 32'd0);
        end
        check_eq("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
